// File: rtl/csc_decoder.sv
// CSC decoder: expands one compressed iact vector (column pointers + {value,row} words)
// into a dense HxW column-major stream of signed words.
module csc_decoder #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                address_in_valid,
  output logic                                address_in_ready,
  input  logic [ADDR_WIDTH-1:0]               address_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  input  logic [DATA_WIDTH+COUNT_WIDTH-1:0]   data_in,
  input  logic [4:0]                          matrix_height,
  input  logic [4:0]                          matrix_width,
  input  logic                                flush,
  output logic                                data_out_valid,
  input  logic                                data_out_ready,
  output logic signed [DATA_WIDTH-1:0]        data_out,
  output logic                                one_vector_done,
  output logic                                protocol_error
);
  localparam int unsigned DIM_W  = 5;
  localparam int unsigned WORD_W = DATA_WIDTH + COUNT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_EMPTY = '1;
  localparam logic [COUNT_WIDTH-1:0] ROW_PH     = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FILL, S_ZERO, S_DRAIN, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DIM_W-1:0]        h_q, h_d, w_q, w_d;
  logic [DIM_W-1:0]        col_q, col_d, row_q, row_d, run_q, run_d;
  logic                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   end_ptr_q, end_ptr_d, dptr_q, dptr_d;
  logic [WORD_W-1:0]       head_q, head_d;
  logic                    head_vld_q, head_vld_d;
  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    err_q, err_d, done_q, done_d;
  logic                    ardy_q, ardy_d, drdy_q, drdy_d;

  logic                    a_fire, d_fire, out_en;
  logic [DATA_WIDTH-1:0]   head_val;
  logic [COUNT_WIDTH-1:0]  head_row;
  logic                    head_end, in_col, member, row_bad, col_last_row;
  logic [DIM_W-1:0]        col_inc;
  logic                    emit, col_adv;
  logic [DATA_WIDTH-1:0]   emit_val;
  logic [DIM_W-1:0]        run_after;

  assign a_fire       = address_in_valid & ardy_q;
  assign d_fire       = data_in_valid & drdy_q;
  assign out_en       = ~out_vld_q | data_out_ready;
  assign head_val     = head_q[WORD_W-1:COUNT_WIDTH];
  assign head_row     = head_q[COUNT_WIDTH-1:0];
  assign head_end     = (head_val == '0);
  // Head word belongs to the current column while inside its pointer window (or always once last).
  assign in_col       = last_q | (dptr_q < end_ptr_q);
  assign member       = head_vld_q & ~head_end & in_col;
  assign row_bad      = (head_row != ROW_PH) &
                        ((DIM_W'(head_row) < row_q) | (DIM_W'(head_row) >= h_q));
  assign col_last_row = (row_q == h_q - DIM_W'(1));
  assign col_inc      = col_q + DIM_W'(1);

  // Next-state, stream handshakes and output-register load.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    w_d        = w_q;
    col_d      = col_q;
    row_d      = row_q;
    run_d      = run_q;
    last_d     = last_q;
    end_ptr_d  = end_ptr_q;
    dptr_d     = dptr_q;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    err_d      = err_q;
    done_d     = 1'b0;
    emit       = 1'b0;
    emit_val   = '0;
    col_adv    = 1'b0;
    run_after  = run_q;

    if (d_fire) begin
      head_d     = data_in;
      head_vld_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (address_in_valid | data_in_valid) begin
          state_d   = S_FETCH;
          h_d       = matrix_height;
          w_d       = matrix_width;
          col_d     = '0;
          row_d     = '0;
          run_d     = '0;
          last_d    = 1'b0;
          end_ptr_d = '0;
          dptr_d    = '0;
        end
      end
      S_FETCH: begin
        if (a_fire) begin
          if (address_in == ADDR_EMPTY) begin
            run_d = run_q + DIM_W'(1);
          end else begin
            state_d = S_FILL;
            row_d   = '0;
            if (address_in == '0) last_d = 1'b1;
            else                  end_ptr_d = address_in;
          end
        end
      end
      S_FILL: begin
        // Placeholders and malformed members are dropped without producing a word.
        if (member & ((head_row == ROW_PH) | row_bad)) begin
          head_vld_d = 1'b0;
          dptr_d     = dptr_q + ADDR_WIDTH'(1);
          err_d      = err_q | row_bad;
        end else if (out_en & member & (DIM_W'(head_row) == row_q)) begin
          emit       = 1'b1;
          emit_val   = head_val;
          head_vld_d = 1'b0;
          dptr_d     = dptr_q + ADDR_WIDTH'(1);
        end else if (out_en & (head_vld_q | ~in_col)) begin
          emit = 1'b1;
        end
        col_adv = emit & col_last_row;
      end
      S_ZERO: begin
        emit    = out_en;
        col_adv = emit & col_last_row;
        if (col_adv && (run_q != '0)) run_after = run_q - DIM_W'(1);
      end
      S_DRAIN: begin
        if (head_vld_q) begin
          head_vld_d = 1'b0;
          if (head_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit) row_d = col_last_row ? '0 : row_q + DIM_W'(1);

    if (col_adv) begin
      col_d = col_inc;
      run_d = run_after;
      if (col_inc == w_q) begin
        state_d = S_DRAIN;
        if (!last_q) err_d = 1'b1;
      end else if ((run_after != '0) || last_q) begin
        state_d = S_ZERO;
      end else begin
        state_d = S_FETCH;
      end
    end

    if (out_en) begin
      out_vld_d = emit;
      if (emit) out_d = emit_val;
    end

    // Abort wins over any handshake in the same cycle.
    if (flush && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      head_vld_d = 1'b0;
      out_vld_d  = 1'b0;
      err_d      = 1'b0;
      done_d     = 1'b0;
    end

    ardy_d = (state_d == S_FETCH);
    drdy_d = ((state_d == S_FILL) | (state_d == S_DRAIN)) & ~head_vld_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      w_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      run_q      <= '0;
      last_q     <= 1'b0;
      end_ptr_q  <= '0;
      dptr_q     <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      ardy_q     <= 1'b0;
      drdy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      w_q        <= w_d;
      col_q      <= col_d;
      row_q      <= row_d;
      run_q      <= run_d;
      last_q     <= last_d;
      end_ptr_q  <= end_ptr_d;
      dptr_q     <= dptr_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      err_q      <= err_d;
      done_q     <= done_d;
      ardy_q     <= ardy_d;
      drdy_q     <= drdy_d;
    end
  end

  assign address_in_ready = ardy_q;
  assign data_in_ready    = drdy_q;
  assign data_out_valid   = out_vld_q;
  assign data_out         = out_q;
  assign one_vector_done  = done_q;
  assign protocol_error   = err_q;

endmodule

// File: tb/tb_csc_decoder.sv
// Bench for csc_decoder: directed vectors plus random dense matrices encoded here
// and compared word-for-word against the dense original.
module tb_csc_decoder;
  localparam int unsigned AW = 7;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 address_in_valid, address_in_ready;
  logic [AW-1:0]        address_in;
  logic                 data_in_valid, data_in_ready;
  logic [DW+CW-1:0]     data_in;
  logic [4:0]           matrix_height, matrix_width;
  logic                 flush;
  logic                 data_out_valid, data_out_ready;
  logic signed [DW-1:0] data_out;
  logic                 one_vector_done, protocol_error;

  csc_decoder #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .address_in_valid(address_in_valid), .address_in_ready(address_in_ready),
    .address_in(address_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
    .matrix_height(matrix_height), .matrix_width(matrix_width), .flush(flush),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .data_out(data_out),
    .one_vector_done(one_vector_done), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0]    aq[$];
  logic [DW+CW-1:0] dq[$];
  logic [DW-1:0]    eq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+CW-1:0] dw(input logic [DW-1:0] v, input logic [CW-1:0] r);
    return {v, r};
  endfunction

  function automatic logic [DW-1:0] rand_nz();
    return DW'($urandom_range(1, 255));
  endfunction

  function automatic logic [31:0] idle_vec();
    return {19'b0, address_in_ready, data_in_ready, data_out_valid, one_vector_done,
            protocol_error, data_out};
  endfunction

  // Random dense HxW matrix, its column-major image in eq, and its compressed streams.
  task automatic build_random(input int h, input int w);
    int cnt[17];
    int start[17];
    int pos, lastnz, c, n;
    logic [DW-1:0] v;
    aq.delete(); dq.delete(); eq.delete();
    pos = 0;
    for (int k = 0; k < 17; k++) cnt[k] = 0;
    for (int col = 0; col < w; col++) begin
      bit empty_col;
      start[col] = pos;
      empty_col = ($urandom_range(3) == 0);
      if ($urandom_range(4) == 0) begin
        dq.push_back(dw(rand_nz(), 4'hF)); cnt[col]++; pos++;
      end
      for (int r = 0; r < h; r++) begin
        v = 8'h00;
        if (!empty_col && ($urandom_range(1) == 1)) v = rand_nz();
        eq.push_back(v);
        if (v != 8'h00) begin
          dq.push_back(dw(v, CW'(r))); cnt[col]++; pos++;
        end
      end
      if (col == 0 && cnt[0] == 0) begin
        dq.push_back(dw(rand_nz(), 4'hF)); cnt[0]++; pos++;
      end
    end
    lastnz = 0;
    for (int col = 0; col < w; col++) if (cnt[col] > 0) lastnz = col;
    c = 0;
    while (c < lastnz) begin
      n = 0;
      while (cnt[c + 1 + n] == 0) n++;
      if (n > 0 && $urandom_range(1) == 1) begin
        repeat (n) aq.push_back(7'h7F);
        aq.push_back(AW'(start[c + 1]));
        c = c + n + 1;
      end else begin
        aq.push_back(AW'(start[c + 1]));
        c = c + 1;
      end
    end
    aq.push_back(7'h00);
    dq.push_back(12'h000);
  endtask

  // Streams aq/dq into the DUT and checks outputs against eq; stop_after>=0 aborts early.
  task automatic run_vec(input string tag, input int h, input int w, input int rdy_mode,
                         input int gap_pct, input int stop_after, input bit use_reset,
                         input bit exp_err);
    int ai, di, oi, cyc, dones;
    bit af, df, of, stop;
    ai = 0; di = 0; oi = 0; cyc = 0; dones = 0; af = 0; df = 0; stop = 0;
    matrix_height = 5'(h);
    matrix_width  = 5'(w);
    address_in_valid = 1'b0;
    data_in_valid    = 1'b0;
    data_out_ready   = 1'b1;
    while (!stop) begin
      if (!(address_in_valid && !af)) begin
        address_in_valid = (ai < aq.size()) && ($urandom_range(99) >= gap_pct);
        if (ai < aq.size()) address_in = aq[ai];
      end
      if (!(data_in_valid && !df)) begin
        data_in_valid = (di < dq.size()) && ($urandom_range(99) >= gap_pct);
        if (di < dq.size()) data_in = dq[di];
      end
      case (rdy_mode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = ~data_out_ready;
        default: data_out_ready = 1'($urandom_range(1));
      endcase
      @(negedge clock);
      af = address_in_valid & address_in_ready;
      df = data_in_valid & data_in_ready;
      of = data_out_valid & data_out_ready;
      if (of) begin
        if (oi < eq.size())
          check($sformatf("%s out[%0d]", tag, oi), {24'h0, data_out}, {24'h0, eq[oi]});
        else
          check($sformatf("%s extra_out", tag), {31'b0, of}, 32'd0);
      end
      if (one_vector_done) dones++;
      @(posedge clock); #1;
      if (af) ai++;
      if (df) di++;
      if (of) oi++;
      cyc++;
      if (stop_after >= 0 && oi == stop_after) stop = 1;
      else if (dones > 0 && oi == eq.size()) stop = 1;
      else if (cyc > 3000) begin
        check($sformatf("%s timeout_outs", tag), 32'(oi), 32'(eq.size()));
        check($sformatf("%s timeout_done", tag), 32'(dones), 32'd1);
        stop = 1;
      end
    end
    address_in_valid = 1'b0;
    data_in_valid    = 1'b0;
    if (stop_after >= 0) begin
      if (use_reset) begin
        reset = 1'b0; #1;
        check($sformatf("%s reset_state", tag), idle_vec(), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
      end else begin
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check($sformatf("%s flush_state", tag), idle_vec() & 32'hFFFF_FF00, 32'd0);
      end
      dones = 0;
      repeat (6) begin
        @(negedge clock);
        if (one_vector_done | data_out_valid) dones++;
      end
      check($sformatf("%s abort_quiet", tag), 32'(dones), 32'd0);
    end else begin
      data_out_ready = 1'b1;
      repeat (5) begin
        @(negedge clock);
        if (one_vector_done) dones++;
        if (data_out_valid) check($sformatf("%s tail_out", tag), {31'b0, data_out_valid}, 32'd0);
      end
      check($sformatf("%s done_pulses", tag), 32'(dones), 32'd1);
      check($sformatf("%s error", tag), {31'b0, protocol_error}, {31'b0, exp_err});
      check($sformatf("%s consumed", tag), {16'(ai), 16'(di)}, {16'(aq.size()), 16'(dq.size())});
      @(posedge clock); #1;
    end
  endtask

  task automatic load_case1();
    aq = '{7'd2, 7'd0};
    dq = '{dw(8'd5, 4'd0), dw(8'hFD, 4'd2), dw(8'd7, 4'd1), dw(8'd0, 4'd0)};
    eq = '{8'd5, 8'd0, 8'hFD, 8'd0, 8'd7, 8'd0};
  endtask

  task automatic load_case2();
    aq = '{7'd1, 7'h7F, 7'h7F, 7'd0};
    dq = '{dw(8'd4, 4'd1), dw(8'd9, 4'd0), dw(8'd0, 4'd0)};
    eq = '{8'd0, 8'd4, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  endtask

  initial begin
    int h, w;
    flush = 1'b0; address_in_valid = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    address_in = '0; data_in = '0; matrix_height = 5'd1; matrix_width = 5'd1;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("reset_state", idle_vec(), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    load_case1(); run_vec("case1", 3, 2, 0, 0, -1, 0, 0);
    load_case2(); run_vec("case2", 2, 4, 0, 0, -1, 0, 0);
    aq = '{7'd0};
    dq = '{dw(8'd1, 4'hF), dw(8'd0, 4'd0)};
    eq = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_vec("case3", 4, 1, 0, 0, -1, 0, 0);
    load_case1(); run_vec("case1_bp", 3, 2, 1, 40, -1, 0, 0);
    load_case1(); run_vec("case1_flush", 3, 2, 0, 0, 3, 0, 0);
    load_case2(); run_vec("case2_after_flush", 2, 4, 0, 0, -1, 0, 0);
    load_case1(); run_vec("case1_reset", 3, 2, 0, 0, 1, 1, 0);
    load_case2(); run_vec("case2_after_reset", 2, 4, 2, 20, -1, 0, 0);

    for (int k = 0; k < 30; k++) begin
      h = $urandom_range(1, 8);
      w = $urandom_range(1, 8);
      build_random(h, w);
      run_vec($sformatf("rand%0d", k), h, w, $urandom_range(2), $urandom_range(0, 50), -1, 0, 0);
    end

    aq = '{7'd0};
    dq = '{dw(8'd5, 4'd2), dw(8'd6, 4'd1), dw(8'd0, 4'd0)};
    eq = '{8'd0, 8'd0, 8'd5};
    run_vec("case_err", 3, 1, 0, 0, -1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
